add_seq_ctrl: RTL



---
 rtl/add_seq_ctrl_pkg.sv | 21 ++
 rtl/add_seq_ctrl_if.sv | 54 +++++
 rtl/add_seq_ctrl_byte_adder.sv | 29 ++
 rtl/add_seq_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the byte-serial adder sequencer.
//   state_e   : sequencer states (idle, running one byte per cycle, result cycle)
//   BYTE_W    : width of the shared adder slice
//   idx_width : width of the byte index counter for a given byte count
// Optional build macro used by the files importing this package: ADDSEQ_SUB_EN.
package add_seq_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // clog2 of the byte count, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Operand/result bundle of add_seq_ctrl.
//   master : operand producer (drives start/a/b/cin[/sub], observes busy/done/results)
//   slave  : the sequencer
// Signals:
//   start  request a new operation       a, b  operands (8*BYTES bits)
//   cin    initial carry-in              sub   subtract select (ADDSEQ_SUB_EN only)
//   busy   operation in progress         done  one-cycle result-update pulse
//   sum    registered result             cout  carry out of MSB byte
//   ovf    two's-complement overflow
// Build macro: ADDSEQ_SUB_EN adds the sub signal.
interface add_seq_ctrl_if
  import add_seq_ctrl_pkg::*;
#(
  parameter int unsigned BYTES = 4
);

  localparam int unsigned Width = BYTE_W * BYTES;

  logic             start;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             cin;
`ifdef ADDSEQ_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [Width-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef ADDSEQ_SUB_EN
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`endif

endinterface

// File: rtl/add_seq_ctrl_byte_adder.sv
// Combinational 8-bit ripple adder slice: sum = a + b + cin.
// Ports:
//   a, b : addend bytes        cin  : carry in
//   sum  : result byte         cout : carry out of bit 7
module add_seq_ctrl_byte_adder
  import add_seq_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] carry;

  // Explicit full-adder chain so the slice stays a plain ripple structure.
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < BYTE_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[BYTE_W];
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Byte-serial wide adder: adds two 8*BYTES-bit operands through a single
// 8-bit slice, one byte per clock, LSB first, carry chained in a register.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : add_seq_ctrl_if.slave (start/a/b/cin[/sub] in, busy/done/sum/cout/ovf out)
// Timing: start sampled at edge T (idle or done) -> BYTES run cycles -> one
// done cycle with busy low; a start in the done cycle begins the next operation.
// Build macro: ADDSEQ_SUB_EN enables subtraction (sum = a - b when sub=1).
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int unsigned BYTES = 4
) (
  input logic         clk,
  input logic         rst_n,
  add_seq_ctrl_if.slave bus
);

  localparam int unsigned IdxW = idx_width(BYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES - 1);

  state_e                        state_q;
  logic [IdxW-1:0]               idx_q;
  logic                          carry_q;
  logic [BYTES-1:0][BYTE_W-1:0]  a_q;
  logic [BYTES-1:0][BYTE_W-1:0]  b_q;
  logic [BYTES-1:0][BYTE_W-1:0]  acc_q;
  logic [BYTES-1:0][BYTE_W-1:0]  acc_next;
  logic                          busy_q;
  logic                          done_q;
  logic [BYTES-1:0][BYTE_W-1:0]  sum_q;
  logic                          cout_q;
  logic                          ovf_q;

  logic [BYTE_W-1:0]             slice_sum;
  logic                          slice_cout;
  logic                          final_ovf;

  add_seq_ctrl_byte_adder u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Accumulator with the current slice result merged in; on the last byte
  // this is the complete result.
  always_comb begin
    acc_next        = acc_q;
    acc_next[idx_q] = slice_sum;
  end

  // b_q already holds the effective (possibly inverted) B, so its MSB is the
  // one the overflow rule needs.
  assign final_ovf = (a_q[BYTES-1][BYTE_W-1] == b_q[BYTES-1][BYTE_W-1]) &&
                     (slice_sum[BYTE_W-1] != a_q[BYTES-1][BYTE_W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            a_q     <= bus.a;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
`ifdef ADDSEQ_SUB_EN
            // Invert B once at capture instead of per byte; same effect.
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub | bus.cin;
`else
            b_q     <= bus.b;
            carry_q <= bus.cin;
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q   <= acc_next;
          carry_q <= slice_cout;
          if (idx_q == LastIdx) begin
            // Results are published only here, so partial sums never show.
            sum_q   <= acc_next;
            cout_q  <= slice_cout;
            ovf_q   <= final_ovf;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
